// File: rtl/register_file_wb_pkg.sv
// -----------------------------------------------------------------------------
// register_file_wb_pkg
//  Shared constants and helpers for the WriteBack-side register file.
//  - Default data and index widths for the MIPS integer register file.
//  - Index of the hardwired $zero register.
//  - Next-state helper for one pending-write scoreboard bit.
// -----------------------------------------------------------------------------
package register_file_wb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;

  // One scoreboard bit. A same-cycle mark wins over a clear because the mark
  // belongs to the younger instruction; the clear retires an older one.
  function automatic logic sb_next(input logic cur, input logic set, input logic clr);
    logic nxt;
    if (set) begin
      nxt = 1'b1;
    end else if (clr) begin
      nxt = 1'b0;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/register_file_wb_mux.sv
// -----------------------------------------------------------------------------
// register_file_wb_mux
//  Plain 2:1 selector used for the read-port bypass.
//  Ports:
//   input_0   stored register value
//   input_1   in-flight WriteBack data
//   selector  1 selects input_1
//   out       selected value
// -----------------------------------------------------------------------------
module register_file_wb_mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] input_0,
  input  logic [WIDTH-1:0] input_1,
  input  logic             selector,
  output logic [WIDTH-1:0] out
);

  // Select between stored and forwarded value
  always_comb begin
    out = input_0;
    if (selector) begin
      out = input_1;
    end else begin
      out = input_0;
    end
  end

endmodule

// File: rtl/register_file_wb.sv
// -----------------------------------------------------------------------------
// register_file_wb
//  32 x 32-bit MIPS register file written by WB and read by ID, with same-cycle
//  write-to-read bypass and a per-register pending-write scoreboard.
//  Ports:
//   clk, rst              clock; synchronous active-high reset
//   RegWrite/writeReg/    WB write port (writes to index 0 are dropped)
//   writeData
//   readReg1/readReg2     ID source indices (rs, rt)
//   readData1/readData2   combinational read data (index 0 reads 0)
//   markEn/markReg        ID marks a destination as having a write in flight
//   busy1/busy2           source index has an outstanding write
// -----------------------------------------------------------------------------
module register_file_wb
  import register_file_wb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic                  markEn,
  input  logic [ADDR_WIDTH-1:0] markReg,
  output logic                  busy1,
  output logic                  busy2
);

  localparam int                  NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_r;

  logic                  wr_en_s;
  logic                  fwd1_s;
  logic                  fwd2_s;
  logic                  sel1_s;
  logic                  sel2_s;
  logic [DATA_WIDTH-1:0] stored1_s;
  logic [DATA_WIDTH-1:0] stored2_s;

  // A write to $zero is a no-op everywhere: storage, bypass and scoreboard
  assign wr_en_s = RegWrite && (writeReg != ZERO_IDX);
  assign fwd1_s  = wr_en_s && (writeReg == readReg1);
  assign fwd2_s  = wr_en_s && (writeReg == readReg2);

  // Register storage and scoreboard; reset overrides any write or mark
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
      busy_r <= '0;
    end else begin
      if (wr_en_s) begin
        regs_r[writeReg] <= writeData;
      end
      busy_r[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        busy_r[i] <= sb_next(busy_r[i],
                             markEn && (markReg == ADDR_WIDTH'(i)),
                             RegWrite && (writeReg == ADDR_WIDTH'(i)));
      end
    end
  end

  // Stored values; index 0 forced to zero independent of array contents
  always_comb begin
    stored1_s = regs_r[readReg1];
    stored2_s = regs_r[readReg2];
    if (readReg1 == ZERO_IDX) begin
      stored1_s = '0;
    end else begin
      stored1_s = regs_r[readReg1];
    end
    if (readReg2 == ZERO_IDX) begin
      stored2_s = '0;
    end else begin
      stored2_s = regs_r[readReg2];
    end
  end

  // Bypass selects and busy flags. With bypass, an in-progress write is
  // forwarded so its consumer need not stall; without it the consumer must
  // wait one more cycle, so the write counts as still outstanding.
  // A same-cycle mark is deliberately not visible here.
  always_comb begin
    sel1_s = 1'b0;
    sel2_s = 1'b0;
    busy1  = 1'b0;
    busy2  = 1'b0;
    if (BYPASS_EN) begin
      sel1_s = fwd1_s;
      sel2_s = fwd2_s;
      busy1  = busy_r[readReg1] && !fwd1_s;
      busy2  = busy_r[readReg2] && !fwd2_s;
    end else begin
      sel1_s = 1'b0;
      sel2_s = 1'b0;
      busy1  = busy_r[readReg1] || fwd1_s;
      busy2  = busy_r[readReg2] || fwd2_s;
    end
  end

  register_file_wb_mux #(.WIDTH(DATA_WIDTH)) u_mux1 (
    .input_0  (stored1_s),
    .input_1  (writeData),
    .selector (sel1_s),
    .out      (readData1)
  );

  register_file_wb_mux #(.WIDTH(DATA_WIDTH)) u_mux2 (
    .input_0  (stored2_s),
    .input_1  (writeData),
    .selector (sel2_s),
    .out      (readData2)
  );

endmodule

// File: tb/tb_register_file_wb.sv
// -----------------------------------------------------------------------------
// tb_register_file_wb
//  Directed checks of register_file_wb (default parameters, bypass enabled).
//  Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
//  after that, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_register_file_wb;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        markEn;
  logic [4:0]  markReg;
  logic        busy1;
  logic        busy2;

  int n_vec;
  int n_miss;

  register_file_wb dut (
    .clk       (clk),
    .rst       (rst),
    .RegWrite  (RegWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (readData1),
    .readData2 (readData2),
    .markEn    (markEn),
    .markReg   (markReg),
    .busy1     (busy1),
    .busy2     (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge, then leave 1 unit of margin
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst      = 1'b0;
    RegWrite = 1'b0;
    writeReg = 5'd0;
    writeData = 32'd0;
    markEn   = 1'b0;
    markReg  = 5'd0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    idle();
    readReg1 = 5'd0;
    readReg2 = 5'd0;
    rst = 1'b1;
    step();

    // Fill every register and mark each one busy before resetting
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      RegWrite  = 1'b1;
      writeReg  = 5'(i);
      writeData = $urandom | 32'd1;
      markEn    = 1'b1;
      markReg   = 5'(i);
      step();
    end
    // Reset cycle, with a write and a mark active that must be ignored
    rst       = 1'b1;
    RegWrite  = 1'b1;
    writeReg  = 5'd3;
    writeData = 32'h1234_5678;
    markEn    = 1'b1;
    markReg   = 5'd4;
    step();
    idle();
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      #1;
      check_vec("rst_rd1", readData1, 32'd0);
      check_vec("rst_rd2", readData2, 32'd0);
      check_vec("rst_busy1", {31'd0, busy1}, 32'd0);
      check_vec("rst_busy2", {31'd0, busy2}, 32'd0);
    end

    // Same-cycle bypass, then the stored value
    RegWrite  = 1'b1;
    writeReg  = 5'd8;
    writeData = 32'hDEAD_BEEF;
    readReg1  = 5'd8;
    readReg2  = 5'd7;
    #1;
    check_vec("byp_rd1", readData1, 32'hDEAD_BEEF);
    check_vec("byp_other_rd2", readData2, 32'd0);
    step();
    idle();
    readReg2 = 5'd8;
    #1;
    check_vec("stored_rd1", readData1, 32'hDEAD_BEEF);
    check_vec("stored_rd2", readData2, 32'hDEAD_BEEF);

    // Writes and marks to $zero have no effect
    RegWrite  = 1'b1;
    writeReg  = 5'd0;
    writeData = 32'hFFFF_FFFF;
    markEn    = 1'b1;
    markReg   = 5'd0;
    readReg2  = 5'd0;
    #1;
    check_vec("zero_rd2_same", readData2, 32'd0);
    check_vec("zero_busy2_same", {31'd0, busy2}, 32'd0);
    step();
    idle();
    #1;
    check_vec("zero_rd2_next", readData2, 32'd0);
    check_vec("zero_busy2_next", {31'd0, busy2}, 32'd0);

    // Mark, observe pending next cycle, then clear with a forwarded write
    markEn   = 1'b1;
    markReg  = 5'd9;
    readReg1 = 5'd9;
    readReg2 = 5'd9;
    #1;
    check_vec("mark_busy1_same", {31'd0, busy1}, 32'd0);
    step();
    idle();
    #1;
    check_vec("mark_busy1_next", {31'd0, busy1}, 32'd1);
    check_vec("mark_busy2_next", {31'd0, busy2}, 32'd1);
    check_vec("mark_rd1_old", readData1, 32'd0);
    step();
    #1;
    check_vec("mark_busy1_hold", {31'd0, busy1}, 32'd1);
    RegWrite  = 1'b1;
    writeReg  = 5'd9;
    writeData = 32'h1357_9BDF;
    #1;
    check_vec("clr_busy1_same", {31'd0, busy1}, 32'd0);
    check_vec("clr_rd1_same", readData1, 32'h1357_9BDF);
    step();
    idle();
    #1;
    check_vec("clr_busy1_next", {31'd0, busy1}, 32'd0);
    check_vec("clr_rd1_next", readData1, 32'h1357_9BDF);

    // Same-cycle clear and mark of one register: the mark wins
    RegWrite  = 1'b1;
    writeReg  = 5'd10;
    writeData = 32'hA5A5_A5A5;
    markEn    = 1'b1;
    markReg   = 5'd10;
    readReg1  = 5'd10;
    #1;
    check_vec("setclr_busy1_same", {31'd0, busy1}, 32'd0);
    step();
    idle();
    #1;
    check_vec("setclr_busy1_next", {31'd0, busy1}, 32'd1);
    check_vec("setclr_rd1_next", readData1, 32'hA5A5_A5A5);

    // Reset mid-operation overrides a concurrent write to a busy register
    RegWrite  = 1'b1;
    writeReg  = 5'd5;
    writeData = 32'd99;
    markEn    = 1'b1;
    markReg   = 5'd5;
    readReg2  = 5'd5;
    step();
    idle();
    #1;
    check_vec("pre_rst_busy2", {31'd0, busy2}, 32'd1);
    check_vec("pre_rst_rd2", readData2, 32'd99);
    rst       = 1'b1;
    RegWrite  = 1'b1;
    writeReg  = 5'd5;
    writeData = 32'd7;
    step();
    idle();
    #1;
    check_vec("mid_rst_rd2", readData2, 32'd0);
    check_vec("mid_rst_busy2", {31'd0, busy2}, 32'd0);
    check_vec("mid_rst_rd1", readData1, 32'd0);
    check_vec("mid_rst_busy1", {31'd0, busy1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
